instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Streaming instruction encoder and loader, the writer-side counterpart of the control-unit decoder. It accepts field-level instruction requests over a valid/ready handshake and packs them into 32-bit words in the same format the decoder consumes: cond[31:28], op[27:26], funct[25:20], Rn[19:16], Rd[15:12], Src2[11:0]. It writes each word into instruction memory at an auto-incrementing word address. It sits between the test/boot host and the instruction memory write port.

Parameters:
ADDR_W, 6, instruction-memory word-address width
DEPTH, 64, number of writable words (<= 2**ADDR_W); address DEPTH-1 is the last slot

Ports:
Clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
clear  in  1  synchronous soft clear: address, count and err to 0; pending write dropped
in_valid  in  1  request valid
in_ready  out  1  request accepted on edge where in_valid & in_ready
in_cmd  in  3  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 CMP, 5 LDR, 6 STR, 7 B
in_cond  in  4  condition field
in_imm  in  1  DP only: 1 = immediate Src2, 0 = register Src2
in_s  in  1  DP only: set-flags bit
in_rd, in_rn, in_rm  in  4 each  register numbers
in_imm12  in  12  DP-immediate (rot:imm8) or memory offset
in_imm24  in  24  branch offset
mem_we  out  1  write request, held until mem_ready
mem_ready  in  1  memory accepts the write on edge where mem_we & mem_ready
mem_addr  out  ADDR_W  word address of the pending write
mem_wdata  out  32  encoded instruction
full  out  1  all DEPTH slots written
err  out  1  sticky: an illegal request was received
count  out  ADDR_W+1  number of words written

Behaviour:
- Reset (reset=0 at edge): state IDLE; mem_we=0; mem_addr=0; mem_wdata=0; full=0; err=0; count=0. A reset during a pending write drops the word. Reset has priority over clear.
- States:
  - IDLE: no pending word.
  - HOLD: word registered, mem_we=1.
  - FULL: count==DEPTH.
- in_ready = ~clear & ((IDLE & ~full) | (HOLD & mem_ready & (count+1 < DEPTH))). The term is combinational from mem_ready, giving one word per cycle at full throughput.
- Accept edge: encoded word is registered into mem_wdata, and the state becomes HOLD. mem_we is asserted the following cycle (latency 1).
- Write edge (HOLD & mem_ready):
  - mem_addr and count increment.
  - If a new request is accepted on the same edge, the state stays HOLD with the new word.
  - Otherwise, if count+1==DEPTH, the state becomes FULL and full=1.
  - Otherwise the state becomes IDLE.
- While in HOLD with mem_ready=0, mem_addr, mem_wdata and mem_we stay stable.
- Encoding:
  - DP (cmd 0-4): op=00. funct = {in_imm, code, S}. code: ADD 0100, SUB 0010, AND 0000, ORR 1100, CMP 1010. CMP forces S=1 and Rd=0000.
  - DP Src2: in_imm12 if in_imm=1, else {8'b0, in_rm}.
  - LDR: op=01, funct=011001, Src2=in_imm12.
  - STR: op=01, funct=010100? No: STR funct=011000, Src2=in_imm12.
  - LDR/STR ignore in_imm and in_s.
  - B: bits[27:24]=1010, [23:0]=in_imm24. Rn, Rd and Src2 fields are unused.
  - cond is always in_cond.
- Illegal request (in_cond==1111): accepted, err set sticky, no word registered, address unchanged. If it arrives on a write edge, the state becomes IDLE (or FULL per the count rule).
- clear: next state IDLE; mem_addr, count, err and full are 0; mem_we=0 next cycle. in_ready=0 while clear=1.
- FULL: in_ready=0, mem_we=0. Only clear or reset leaves it.
- count is saturating by construction: max DEPTH, no wrap-around.

Test Plan:
- ADD R1,R2,R3, cond E, in_imm=0 -> mem_wdata=0xE0821003 at addr 0, mem_we one cycle after accept; count=1.
- ADD R1,R2,#5 -> 0xE2821005. CMP R1,#0 (in_imm=1, in_s=0, in_rd=7) -> 0xE3510000 (S forced, Rd forced 0).
- Back-to-back LDR R0,[R1,#4] then STR R0,[R1,#4] with mem_ready=1 -> 0xE5910004 @0, 0xE5810004 @1 on consecutive cycles, in_ready held 1.
- B, cond NE, imm24=0xFFFFFE with mem_ready low 3 cycles -> mem_we=1 and mem_wdata=0x1AFFFFFE stable for 4 cycles; in_ready=0 until the write edge.
- DEPTH=4: five valid requests -> four writes @0-3, full=1, count=4, 5th never accepted. clear -> addr 0, full=0, in_ready=1.
- in_cond=1111 request -> accepted, err=1, no mem_we, mem_addr unchanged. Assert reset mid-HOLD -> mem_we=0, all outputs 0 the next cycle.

Source files
------------

// File: rtl/instr_encoder.sv
// Streaming instruction encoder/loader: packs field-level requests into
// 32-bit decoder-format words and writes them to instruction memory at an
// auto-incrementing word address.
module instr_encoder #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_cmd,
  input  logic [3:0]        in_cond,
  input  logic              in_imm,
  input  logic              in_s,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rm,
  input  logic [11:0]       in_imm12,
  input  logic [23:0]       in_imm24,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FULL} state_t;

  // count value whose write fills the last slot
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [ADDR_W:0]     count_n;
  logic [31:0]         wdata_n, enc;
  logic                err_n, legal, wr, acc;
  logic [3:0]          code, rd_f;
  logic                s_f, is_cmp;
  logic [11:0]         src2;

  assign legal    = (in_cond != 4'hF);
  assign wr       = (state == S_HOLD) & mem_ready;
  assign in_ready = ~clear & ((state == S_IDLE) | (wr & (count < LAST)));
  assign acc      = in_valid & in_ready;
  assign mem_we   = (state == S_HOLD);
  assign full     = (state == S_FULL);

  // field packing of the current request
  always_comb begin
    code   = 4'b0000;
    is_cmp = 1'b0;
    case (in_cmd)
      3'd0:    code = 4'b0100;
      3'd1:    code = 4'b0010;
      3'd3:    code = 4'b1100;
      3'd4:    begin code = 4'b1010; is_cmp = 1'b1; end
      default: code = 4'b0000;
    endcase
    s_f  = in_s | is_cmp;
    rd_f = is_cmp ? 4'b0000 : in_rd;
    src2 = in_imm ? in_imm12 : {8'b0, in_rm};
    case (in_cmd)
      3'd5:    enc = {in_cond, 2'b01, 6'b011001, in_rn, in_rd, in_imm12};
      3'd6:    enc = {in_cond, 2'b01, 6'b011000, in_rn, in_rd, in_imm12};
      3'd7:    enc = {in_cond, 4'b1010, in_imm24};
      default: enc = {in_cond, 2'b00, in_imm, code, s_f, in_rn, rd_f, src2};
    endcase
  end

  // next-state: write edge retires the held word, accept edge loads a new one
  always_comb begin
    state_n = state;
    addr_n  = mem_addr;
    count_n = count;
    wdata_n = mem_wdata;
    err_n   = err;
    if (clear) begin
      state_n = S_IDLE;
      addr_n  = '0;
      count_n = '0;
      err_n   = 1'b0;
    end else begin
      if (wr) begin
        addr_n  = mem_addr + ADDR_W'(1);
        count_n = count + (ADDR_W+1)'(1);
        state_n = (count == LAST) ? S_FULL : S_IDLE;
      end
      if (acc) begin
        if (legal) begin
          state_n = S_HOLD;
          wdata_n = enc;
        end else begin
          err_n = 1'b1;
        end
      end
    end
  end

  // state register; reset drops any pending word
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      mem_addr  <= '0;
      count     <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      mem_addr  <= addr_n;
      count     <= count_n;
      mem_wdata <= wdata_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed cases with literal encodings, then
// randomized traffic against a pending-word / written-count reference model.
module tb_instr_encoder;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          Clk = 0;
  logic          reset, clear, in_valid, in_ready;
  logic [2:0]    in_cmd;
  logic [3:0]    in_cond, in_rd, in_rn, in_rm;
  logic          in_imm, in_s;
  logic [11:0]   in_imm12;
  logic [23:0]   in_imm24;
  logic          mem_we, mem_ready, full, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;

  int n_chk = 0, n_err = 0;

  // reference model state
  int          written = 0;
  bit          pending = 0, fullm = 0, errm = 0, wd_known = 0;
  logic [31:0] pend_word = '0;

  instr_encoder #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_cmd(in_cmd), .in_cond(in_cond), .in_imm(in_imm),
    .in_s(in_s), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_imm12(in_imm12), .in_imm24(in_imm24), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .full(full), .err(err), .count(count));

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // instruction word from the field rules, built arithmetically
  function automatic logic [31:0] encode(input int cmd, cond, imm, s, rd, rn, rm, imm12, imm24);
    int op, funct, code, src2;
    if (cmd == 7) return (32'(cond) << 28) | (32'hA << 24) | 32'(imm24);
    if (cmd == 5 || cmd == 6) begin
      op = 1; funct = (cmd == 5) ? 25 : 24; src2 = imm12;
    end else begin
      case (cmd)
        0: code = 4; 1: code = 2; 2: code = 0; 3: code = 12; default: code = 10;
      endcase
      if (cmd == 4) begin s = 1; rd = 0; end
      op = 0; funct = imm * 32 + code * 2 + s;
      src2 = imm ? imm12 : rm;
    end
    return 32'(cond * (2**28) + op * (2**26) + funct * (2**20) + rn * (2**16) + rd * (2**12) + src2);
  endfunction

  task automatic set_req(input int cmd, cond, imm, s, rd, rn, rm, imm12, imm24);
    in_cmd = 3'(cmd); in_cond = 4'(cond); in_imm = 1'(imm); in_s = 1'(s);
    in_rd = 4'(rd); in_rn = 4'(rn); in_rm = 4'(rm);
    in_imm12 = 12'(imm12); in_imm24 = 24'(imm24);
  endtask

  // one clock: drive, check against model before the edge, advance model
  task automatic step(input bit rst, input bit clr, input bit vld, input bit rdy);
    bit er, wr, acc;
    reset = rst; clear = clr; in_valid = vld; mem_ready = rdy;
    #1;
    er = !clr && ((!pending && !fullm) || (pending && rdy && written + 1 < DEPTH));
    if (rst) chk("in_ready", 32'(in_ready), 32'(er));
    chk("mem_we", 32'(mem_we), 32'(pending));
    chk("full", 32'(full), 32'(fullm));
    chk("err", 32'(err), 32'(errm));
    chk("count", 32'(count), 32'(written));
    chk("mem_addr", 32'(mem_addr), 32'(written % (1 << AW)));
    if (pending || wd_known) chk("mem_wdata", mem_wdata, pend_word);
    wd_known = 0;
    if (!rst) begin
      written = 0; pending = 0; fullm = 0; errm = 0; pend_word = '0; wd_known = 1;
    end else if (clr) begin
      written = 0; pending = 0; fullm = 0; errm = 0;
    end else begin
      wr  = pending && rdy;
      acc = vld && er;
      if (wr) begin written++; pending = 0; end
      if (acc && in_cond != 4'hF) begin
        pending = 1;
        pend_word = encode(int'(in_cmd), int'(in_cond), int'(in_imm), int'(in_s), int'(in_rd),
                           int'(in_rn), int'(in_rm), int'(in_imm12), int'(in_imm24));
      end else if (acc) errm = 1;
      if (wr && !pending && written == DEPTH) fullm = 1;
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    set_req(0, 14, 0, 0, 1, 2, 3, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_count", 32'(count), 32'h0);

    // ADD R1,R2,R3
    step(1, 0, 1, 0);
    chk("add_reg_word", mem_wdata, 32'hE0821003);
    chk("add_reg_we", 32'(mem_we), 32'h1);
    step(1, 0, 0, 1);
    chk("add_reg_count", 32'(count), 32'h1);
    // ADD R1,R2,#5
    set_req(0, 14, 1, 0, 1, 2, 0, 5, 0);
    step(1, 0, 1, 0);
    chk("add_imm_word", mem_wdata, 32'hE2821005);
    step(1, 0, 0, 1);
    // CMP R1,#0 with Rd=7, S=0 -> both forced
    set_req(4, 14, 1, 0, 7, 1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("cmp_word", mem_wdata, 32'hE3510000);
    step(1, 0, 0, 1);

    // back-to-back LDR then STR
    step(1, 1, 0, 0);
    set_req(5, 14, 0, 0, 0, 1, 0, 4, 0);
    step(1, 0, 1, 1);
    chk("ldr_word", mem_wdata, 32'hE5910004);
    set_req(6, 14, 0, 0, 0, 1, 0, 4, 0);
    step(1, 0, 1, 1);
    chk("str_word", mem_wdata, 32'hE5810004);
    chk("str_addr", 32'(mem_addr), 32'h1);
    step(1, 0, 0, 1);

    // B NE with memory stalled three cycles
    set_req(7, 1, 0, 0, 0, 0, 0, 0, 24'hFFFFFE);
    step(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0);
      chk("b_stall_word", mem_wdata, 32'h1AFFFFFE);
      chk("b_stall_we", 32'(mem_we), 32'h1);
    end
    step(1, 0, 0, 1);

    // fill all slots, fifth request refused
    step(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      set_req(5, 14, 0, 0, i, 1, 0, i, 0);
      step(1, 0, 1, 1);
    end
    step(1, 0, 1, 1); step(1, 0, 1, 1);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_count", 32'(count), 32'h4);
    step(1, 1, 1, 1);
    clear = 0; #1;
    chk("clear_ready", 32'(in_ready), 32'h1);
    chk("clear_addr", 32'(mem_addr), 32'h0);
    chk("clear_full", 32'(full), 32'h0);

    // illegal cond
    set_req(0, 15, 0, 0, 1, 2, 3, 0, 0);
    step(1, 0, 1, 1);
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_we", 32'(mem_we), 32'h0);
    chk("ill_addr", 32'(mem_addr), 32'h0);

    // reset mid-HOLD
    set_req(3, 0, 0, 1, 5, 6, 7, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("rst_hold_we", 32'(mem_we), 32'h0);
    chk("rst_hold_word", mem_wdata, 32'h0);
    chk("rst_hold_err", 32'(err), 32'h0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      set_req($urandom_range(0, 7), ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 14),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 4095),
              $urandom_range(0, 24'hFFFFFF));
      step($urandom_range(0, 99) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
